// File: rtl/team_01_spi_pkg.sv
// Shared constants and FSM encoding for the team_01 SPI flash read initiator.
package team_01_spi_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam int         ADDR_W   = 24;
    localparam int         HDR_W    = 8 + ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DESEL = 3'd6
    } spi_state_e;

endpackage

// File: rtl/team_01_spi_sck_gen.sv
// SCK divider: half-period of CLK_DIV clocks, idle low, with one-cycle strobes
// flagging the edge at which sck will rise or fall. stall freezes sck low.
module team_01_spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic en,
    input  logic stall,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          at_term;

    assign at_term = (cnt == TERM);
    // A stall only blocks a rising edge; a high sck always completes its half-period.
    assign rise    = en && !sck && !stall && at_term;
    assign fall    = en &&  sck && at_term;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (rise || fall) begin
            cnt <= '0;
            sck <= !sck;
        end else if (!at_term) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/team_01_spi_flash_reader.sv
// SPI mode-0 flash READ (0x03) initiator streaming received bytes out through
// a single-entry valid/ready register, stalling SCK when the consumer lags.
module team_01_spi_flash_reader
    import team_01_spi_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int LEN_W       = 8,
    parameter int CS_IDLE_CYC = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              busy,
    output logic              done,
    output logic              spi_csb,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int IC_MAX = (CLK_DIV > CS_IDLE_CYC) ? CLK_DIV : CS_IDLE_CYC;
    localparam int IC_W   = $clog2(IC_MAX + 1);

    spi_state_e       state;
    logic [HDR_W-1:0] tx_sr;
    logic [6:0]       rx_sr;
    logic [4:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [IC_W-1:0]  idle_cnt;
    logic             zero_done;
    logic             sck_en, sck_stall, sck_rise, sck_fall;
    logic             byte_last_bit;

    assign req_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign done          = zero_done ||
                           (state == ST_DESEL && idle_cnt == IC_W'(CS_IDLE_CYC - 1));
    assign spi_mosi      = tx_sr[HDR_W-1];
    assign byte_last_bit = (bit_cnt[2:0] == 3'd7);

    assign sck_en    = (state != ST_IDLE) && (state != ST_DESEL);
    // Hold SCK low before the first bit of a byte while the output register is still full,
    // and park it low once the final byte has been clocked in.
    assign sck_stall = (state == ST_HOLD) ||
                       (state == ST_DATA && bit_cnt[2:0] == 3'd0 && out_valid && !out_ready);

    team_01_spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .en       (sck_en),
        .stall    (sck_stall),
        .sck      (spi_sck),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            spi_csb   <= 1'b1;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            // Header drains one bit per falling edge; it is all zeros by the data phase.
            if (sck_fall)
                tx_sr <= {tx_sr[HDR_W-2:0], 1'b0};

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_len == '0) begin
                            zero_done <= 1'b1;
                        end else begin
                            state    <= ST_SETUP;
                            spi_csb  <= 1'b0;
                            tx_sr    <= {CMD_READ, req_addr};
                            byte_cnt <= req_len;
                            bit_cnt  <= '0;
                        end
                    end
                end

                ST_SETUP, ST_CMD, ST_ADDR: begin
                    if (sck_rise) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (state == ST_SETUP)
                            state <= ST_CMD;
                        else if (state == ST_CMD && bit_cnt == 5'd7)
                            state <= ST_ADDR;
                        else if (state == ST_ADDR && bit_cnt == 5'(HDR_W - 1))
                            state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (sck_rise) begin
                        rx_sr   <= {rx_sr[5:0], spi_miso};
                        bit_cnt <= byte_last_bit ? 5'd0 : bit_cnt + 5'd1;
                        if (byte_last_bit) begin
                            out_data  <= {rx_sr, spi_miso};
                            out_valid <= 1'b1;
                            byte_cnt  <= byte_cnt - LEN_W'(1);
                            idle_cnt  <= '0;
                            if (byte_cnt == LEN_W'(1))
                                state <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (!spi_sck) begin
                        if (idle_cnt != IC_W'(CLK_DIV - 1)) begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end else if (!out_valid || out_ready) begin
                            state    <= ST_DESEL;
                            spi_csb  <= 1'b1;
                            idle_cnt <= '0;
                        end
                    end
                end

                ST_DESEL: begin
                    if (idle_cnt == IC_W'(CS_IDLE_CYC - 1))
                        state <= ST_IDLE;
                    else
                        idle_cnt <= idle_cnt + 1'b1;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_team_01_spi_flash_reader.sv
// Directed bench for team_01_spi_flash_reader with a behavioural SPI flash responder.
module tb_team_01_spi_flash_reader;

    localparam int CLK_DIV     = 2;
    localparam int LEN_W       = 8;
    localparam int CS_IDLE_CYC = 4;

    logic             wb_clk_i  = 1'b0;
    logic             wb_rst_i  = 1'b1;
    logic             req_valid = 1'b0;
    logic [23:0]      req_addr  = '0;
    logic [LEN_W-1:0] req_len   = '0;
    logic             out_ready = 1'b0;
    logic             spi_miso  = 1'b0;
    logic             req_ready, out_valid, busy, done, spi_csb, spi_sck, spi_mosi;
    logic [7:0]       out_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    team_01_spi_flash_reader #(
        .CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_IDLE_CYC(CS_IDLE_CYC)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_len  (req_len),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .done     (done),
        .spi_csb  (spi_csb),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    // Flash responder: 0x03 + 24-bit address, then bytes MSB first on falling SCK.
    logic [7:0]  mem [0:4095];
    logic [31:0] f_sr     = '0;
    logic [31:0] last_hdr = '0;
    int          f_bits    = 0;
    int          last_bits = 0;
    int          tot_rises = 0;

    always @(posedge spi_sck) tot_rises++;

    always @(posedge spi_sck or posedge spi_csb) begin
        if (spi_csb) begin
            last_hdr  = f_sr;
            last_bits = f_bits;
            f_bits    = 0;
        end else begin
            if (f_bits < 32) f_sr = {f_sr[30:0], spi_mosi};
            f_bits++;
        end
    end

    always @(negedge spi_sck) begin
        int p;
        if (!spi_csb && f_bits >= 32) begin
            p = f_bits - 32;
            spi_miso = mem[(int'(f_sr[11:0]) + p / 8) % 4096][7 - p % 8];
        end
    end

    // Handshake monitor sampled just after the falling edge, where inputs are settled.
    logic [7:0] rx_q [$];
    int done_cnt = 0;
    int acc_cnt  = 0;

    always @(negedge wb_clk_i) begin
        #1;
        if (out_valid && out_ready) rx_q.push_back(out_data);
        if (done) done_cnt++;
        if (req_valid && req_ready) acc_cnt++;
    end

    function automatic logic [31:0] pack_rx(input int base, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            v = (base + i < rx_q.size()) ? {v[23:0], rx_q[base + i]} : {v[23:0], 8'h00};
        return v;
    endfunction

    task automatic send_req(input logic [23:0] a, input logic [LEN_W-1:0] l, output bit ok);
        int n = 0;
        @(negedge wb_clk_i);
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        ok = req_ready;
        @(negedge wb_clk_i);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, output bit ok);
        int n = 0;
        while (done_cnt == start && n < 5000) begin
            @(negedge wb_clk_i);
            n++;
        end
        ok = (done_cnt != start);
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        n_chk++;
        if ({spi_csb, spi_sck, spi_mosi, out_valid, busy, done, req_ready} !== 7'b1000001)
            $display("FAIL reset_ctrl: got %b want 1000001",
                     {spi_csb, spi_sck, spi_mosi, out_valid, busy, done, req_ready});
        else n_pass++;
        n_chk++;
        if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data);
        else n_pass++;
    endtask

    task automatic test_basic_read();
        bit ok;
        int base = rx_q.size();
        int d0 = done_cnt;
        logic [7:0] sck_pat = '0;
        int cyc = 0, desel = 0, done_at = -1;
        out_ready = 1'b1;
        send_req(24'h000100, 8'd4, ok);
        n_chk++;
        if (!ok) $display("FAIL basic_accept: req_ready never seen"); else n_pass++;
        n_chk++;
        if ({spi_csb, spi_sck, spi_mosi} !== 3'b000)
            $display("FAIL basic_csb_fall: got %b want 000", {spi_csb, spi_sck, spi_mosi});
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk_i);
            sck_pat = {sck_pat[6:0], spi_sck};
        end
        n_chk++;
        if (sck_pat !== 8'b01100110) $display("FAIL basic_sck_timing: got %b want 01100110", sck_pat);
        else n_pass++;
        while (!req_ready && cyc < 2000) begin
            @(negedge wb_clk_i);
            cyc++;
            if (spi_csb && busy) desel++;
            if (done) done_at = cyc;
        end
        n_chk++;
        if (desel !== CS_IDLE_CYC) $display("FAIL basic_desel: got %0d want %0d", desel, CS_IDLE_CYC);
        else n_pass++;
        n_chk++;
        if (done_at !== cyc - 1) $display("FAIL basic_done_pos: got %0d want %0d", done_at, cyc - 1);
        else n_pass++;
        n_chk++;
        if (rx_q.size() - base !== 4) $display("FAIL basic_count: got %0d want 4", rx_q.size() - base);
        else n_pass++;
        n_chk++;
        if (pack_rx(base, 4) !== 32'hDEADBEEF)
            $display("FAIL basic_data: got %h want deadbeef", pack_rx(base, 4));
        else n_pass++;
        n_chk++;
        if (last_hdr !== 32'h03000100) $display("FAIL basic_mosi: got %h want 03000100", last_hdr);
        else n_pass++;
        n_chk++;
        if (last_bits !== 64) $display("FAIL basic_rises: got %0d want 64", last_bits);
        else n_pass++;
        n_chk++;
        if (done_cnt - d0 !== 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        int base = rx_q.size();
        int d0 = done_cnt;
        int t0 = tot_rises;
        int n = 0, rises = 0, bad = 0;
        logic prev;
        out_ready = 1'b0;
        send_req(24'h000200, 8'd3, ok);
        n_chk++;
        if (!ok) $display("FAIL stall_accept: req_ready never seen"); else n_pass++;
        while (!out_valid && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        n_chk++;
        if ({out_valid, out_data} !== 9'h111)
            $display("FAIL stall_first: got %b/%h want 1/11", out_valid, out_data);
        else n_pass++;
        prev = spi_sck;
        repeat (50) begin
            @(negedge wb_clk_i);
            if (spi_sck && !prev) rises++;
            prev = spi_sck;
            if (!out_valid || out_data !== 8'h11) bad++;
        end
        n_chk++;
        if (rises !== 0) $display("FAIL stall_sck_frozen: got %0d rises want 0", rises); else n_pass++;
        n_chk++;
        if (bad !== 0) $display("FAIL stall_hold_data: got %0d bad cycles want 0", bad); else n_pass++;
        n_chk++;
        if (spi_sck !== 1'b0) $display("FAIL stall_sck_low: got %b want 0", spi_sck); else n_pass++;
        out_ready = 1'b1;
        @(negedge wb_clk_i);
        n_chk++;
        if ({spi_sck, out_valid} !== 2'b10)
            $display("FAIL stall_resume: got %b want 10", {spi_sck, out_valid});
        else n_pass++;
        wait_done(d0, ok);
        n_chk++;
        if (!ok) $display("FAIL stall_done: done never seen"); else n_pass++;
        n_chk++;
        if (rx_q.size() - base !== 3 || pack_rx(base, 3) !== 32'h00112233)
            $display("FAIL stall_data: got %0d bytes %h want 3 bytes 00112233",
                     rx_q.size() - base, pack_rx(base, 3));
        else n_pass++;
        n_chk++;
        if (tot_rises - t0 !== 56) $display("FAIL stall_rises: got %0d want 56", tot_rises - t0);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        bit ok;
        int d0 = done_cnt;
        int t0 = tot_rises;
        int csb_low = 0;
        send_req(24'h000123, 8'd0, ok);
        n_chk++;
        if (!ok) $display("FAIL zero_accept: req_ready never seen"); else n_pass++;
        n_chk++;
        if ({done, busy, spi_csb, req_ready} !== 4'b1011)
            $display("FAIL zero_done_pulse: got %b want 1011", {done, busy, spi_csb, req_ready});
        else n_pass++;
        @(negedge wb_clk_i);
        n_chk++;
        if ({done, busy} !== 2'b00) $display("FAIL zero_done_clear: got %b want 00", {done, busy});
        else n_pass++;
        repeat (10) begin
            @(negedge wb_clk_i);
            if (!spi_csb) csb_low++;
        end
        n_chk++;
        if (tot_rises - t0 !== 0 || csb_low !== 0)
            $display("FAIL zero_no_spi: got %0d rises %0d csb-low cycles want 0/0", tot_rises - t0, csb_low);
        else n_pass++;
        n_chk++;
        if (done_cnt - d0 !== 1) $display("FAIL zero_done_cnt: got %0d want 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0, base, d0;
        out_ready = 1'b1;
        send_req(24'h000300, 8'd2, ok);
        while (f_bits < 12 && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        n_chk++;
        if (!ok || f_bits !== 12 || busy !== 1'b1)
            $display("FAIL rstmid_reach_addr: got bits %0d busy %b want 12/1", f_bits, busy);
        else n_pass++;
        base = rx_q.size();
        d0 = done_cnt;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        n_chk++;
        if ({spi_csb, spi_sck, out_valid, busy, done} !== 5'b10000)
            $display("FAIL rstmid_state: got %b want 10000", {spi_csb, spi_sck, out_valid, busy, done});
        else n_pass++;
        wb_rst_i = 1'b0;
        repeat (20) @(negedge wb_clk_i);
        n_chk++;
        if (done_cnt !== d0 || rx_q.size() !== base)
            $display("FAIL rstmid_quiet: got %0d dones %0d bytes want 0/0", done_cnt - d0, rx_q.size() - base);
        else n_pass++;
        send_req(24'h000300, 8'd2, ok);
        wait_done(d0, ok);
        n_chk++;
        if (!ok || rx_q.size() - base !== 2 || pack_rx(base, 2) !== 32'h00005AA5)
            $display("FAIL rstmid_reread: got %0d bytes %h want 2 bytes 00005aa5",
                     rx_q.size() - base, pack_rx(base, 2));
        else n_pass++;
        n_chk++;
        if (last_hdr !== 32'h03000300) $display("FAIL rstmid_mosi: got %h want 03000300", last_hdr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base = rx_q.size();
        int d0 = done_cnt;
        int a0 = acc_cnt;
        int n = 0, gap = 0;
        out_ready = 1'b1;
        @(negedge wb_clk_i);
        req_addr  = 24'h000400;
        req_len   = 8'd2;
        req_valid = 1'b1;
        while (!busy && n < 100) begin
            @(negedge wb_clk_i);
            n++;
        end
        req_addr = 24'h000500;
        req_len  = 8'd1;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        while (!busy && gap < 100) begin
            gap++;
            @(negedge wb_clk_i);
        end
        req_valid = 1'b0;
        n_chk++;
        if (gap !== 1) $display("FAIL b2b_idle_gap: got %0d want 1", gap); else n_pass++;
        wait_done(d0 + 1, ok);
        n_chk++;
        if (!ok || rx_q.size() - base !== 3 || pack_rx(base, 3) !== 32'h00C33C99)
            $display("FAIL b2b_data: got %0d bytes %h want 3 bytes 00c33c99",
                     rx_q.size() - base, pack_rx(base, 3));
        else n_pass++;
        n_chk++;
        if (acc_cnt - a0 !== 2) $display("FAIL b2b_accepts: got %0d want 2", acc_cnt - a0); else n_pass++;
        n_chk++;
        if (last_hdr !== 32'h03000500) $display("FAIL b2b_mosi: got %h want 03000500", last_hdr);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 1);
        mem[12'h100] = 8'hDE; mem[12'h101] = 8'hAD; mem[12'h102] = 8'hBE; mem[12'h103] = 8'hEF;
        mem[12'h200] = 8'h11; mem[12'h201] = 8'h22; mem[12'h202] = 8'h33;
        mem[12'h300] = 8'h5A; mem[12'h301] = 8'hA5;
        mem[12'h400] = 8'hC3; mem[12'h401] = 8'h3C; mem[12'h500] = 8'h99;

        test_reset();
        test_basic_read();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();

        repeat (5) @(negedge wb_clk_i);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
